// File: rtl/alu_pkg.sv
// Shared opcode, state and constant definitions for the ALU driver.
package alu_pkg;
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOR = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_ADD = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_MOD = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_EXEC  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4
    } state_e;

    localparam logic [31:0] MOD_ZERO_RES = 32'hFFFF_FFFF;
endpackage

// File: rtl/alu_drv_watchdog.sv
// Loadable down-counter bounding the WAIT state; expired_o rises once CYCLES
// enabled cycles have elapsed since the load.
module alu_drv_watchdog #(
    parameter int CYCLES = 4096
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (load_i)
            cnt_d = CW'(CYCLES - 1);
        else if (en_i && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign expired_o = en_i && (cnt_q == '0);
endmodule

// File: rtl/alu_driver.sv
// Request/response front end for the multi-cycle ALU. Optional WAIT timeout
// is enabled by defining ALU_DRIVER_TIMEOUT_EN.
module alu_driver
    import alu_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_aluop,
    output logic              alu_start,
    input  logic [DATA_W-1:0] alu_res,
    input  logic              alu_done,
    input  logic              alu_carry,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_res,
    output logic              rsp_carry,
    output logic              rsp_err,
    output logic              busy
);
    if (DATA_W < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("alu_driver: DATA_W and TIMEOUT_CYCLES must both be at least 2");
    end

    state_e            state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [2:0]        op_q, op_d;
    logic              carry_q, carry_d, err_q, err_d;
    logic              wd_expired;

`ifdef ALU_DRIVER_TIMEOUT_EN
    alu_drv_watchdog #(.CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clk_i     (clk),
        .rst_i     (reset),
        .clr_i     (state_q == S_IDLE),
        .load_i    (state_q == S_ISSUE),
        .en_i      (state_q == S_WAIT),
        .expired_o (wd_expired)
    );
`else
    assign wd_expired = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        carry_d = carry_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: if (req_valid) begin
                a_d     = req_a;
                b_d     = req_b;
                op_d    = req_op;
                carry_d = 1'b0;
                err_d   = 1'b0;
                if (req_op != OP_MOD) begin
                    state_d = S_EXEC;
                end else if (req_b == '0) begin
                    // Divide by zero never reaches the ALU.
                    res_d   = DATA_W'(MOD_ZERO_RES);
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_EXEC: begin
                res_d   = (op_q == OP_SLT) ? DATA_W'(alu_res[0]) : alu_res;
                carry_d = (op_q == OP_ADD) && alu_carry;
                state_d = S_RESP;
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                // done has priority over an expiry in the same cycle
                if (alu_done) begin
                    res_d   = alu_res;
                    state_d = S_RESP;
                end else if (wd_expired) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            err_q   <= err_d;
        end
    end

    // Decoded from state so reset removes start/valid without waiting for a clock.
    assign req_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign alu_start = (state_q == S_ISSUE);
    assign rsp_valid = (state_q == S_RESP);
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_aluop = op_q;
    assign rsp_res   = res_q;
    assign rsp_carry = carry_q;
    assign rsp_err   = err_q;
endmodule
